// File: rtl/sw_filter_pulse.sv
// rtl/sw_filter_pulse.sv - switch-bus debouncer with edge pulses plus a strobe edge detector
module sw_filter_pulse #(
    parameter bit   P_SIM      = 1'b0,
    parameter int   P_DBUS_W   = 8,
    parameter logic P_INIT_VAL = 1'b0,
    parameter int   P_SAMP_CNT = 10000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [P_DBUS_W-1:0] SW_I,
    input  logic                PULSE_I,
    output logic [P_DBUS_W-1:0] SW_O,
    output logic [P_DBUS_W-1:0] SW_RISE,
    output logic [P_DBUS_W-1:0] SW_FALL,
    output logic                PULSE_O
);

    // Simulation builds shrink the sample period so tests stay short.
    localparam int                  N    = P_SIM ? 16 : P_SAMP_CNT;
    localparam logic [15:0]         LAST = 16'(N - 1);
    localparam logic [P_DBUS_W-1:0] INIT = {P_DBUS_W{P_INIT_VAL}};

    logic [15:0]         cnt_q,   cnt_d;
    logic                samp_en;
    logic [P_DBUS_W-1:0] sync1_q, sync2_q;
    logic [P_DBUS_W-1:0] h0_q,    h0_d;
    logic [P_DBUS_W-1:0] h1_q,    h1_d;
    logic [P_DBUS_W-1:0] sw_q,    sw_d;
    logic [P_DBUS_W-1:0] rise_q,  rise_d;
    logic [P_DBUS_W-1:0] fall_q,  fall_d;
    logic [P_DBUS_W-1:0] all_hi,  all_lo;
    logic                p_q;
    logic                pulse_q, pulse_d;

    // Free-running sample counter; the terminal count is the sample strobe.
    // With N = 65536 the terminal count is 16'hFFFF and the +1 wraps by itself.
    assign samp_en = (cnt_q == LAST);

    // Next count: wrap to zero on the strobe, otherwise advance.
    always_comb begin
        cnt_d = samp_en ? 16'd0 : cnt_q + 16'd1;
    end

    // The three-sample window is the incoming synchronized sample plus the
    // two most recent stored samples, so the decision lands on the same edge
    // that shifts the new sample in.
    assign all_hi = sync2_q & h0_q & h1_q;
    assign all_lo = ~(sync2_q | h0_q | h1_q);

    // Filter decision, history shift and edge-pulse generation on each strobe.
    always_comb begin
        h0_d   = h0_q;
        h1_d   = h1_q;
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        if (samp_en) begin
            h0_d   = sync2_q;
            h1_d   = h0_q;
            rise_d = all_hi & ~sw_q;
            fall_d = all_lo & sw_q;
            sw_d   = (sw_q | rise_d) & ~fall_d;
        end
    end

    // Strobe edge detector: high for the first cycle PULSE_I is seen high.
    always_comb begin
        pulse_d = PULSE_I & ~p_q;
    end

    // All state registers; reset discards any partially built history and
    // clears the pulse outputs so reset itself never produces an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= 16'd0;
            sync1_q <= INIT;
            sync2_q <= INIT;
            h0_q    <= INIT;
            h1_q    <= INIT;
            sw_q    <= INIT;
            rise_q  <= '0;
            fall_q  <= '0;
            p_q     <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sync1_q <= SW_I;
            sync2_q <= sync1_q;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            p_q     <= PULSE_I;
            pulse_q <= pulse_d;
        end
    end

    assign SW_O    = sw_q;
    assign SW_RISE = rise_q;
    assign SW_FALL = fall_q;
    assign PULSE_O = pulse_q;

endmodule

// File: tb/tb_sw_filter_pulse.sv
// tb/tb_sw_filter_pulse.sv - randomized bench for sw_filter_pulse with a behavioural model
module tb_sw_filter_pulse;

    localparam int N = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SW_I = 8'h00;
    logic       PULSE_I = 1'b0;
    logic [7:0] SW_O, SW_RISE, SW_FALL;
    logic       PULSE_O;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    sw_filter_pulse #(
        .P_SIM      (1'b1),
        .P_DBUS_W   (8),
        .P_INIT_VAL (1'b0),
        .P_SAMP_CNT (10000)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW_I    (SW_I),
        .PULSE_I (PULSE_I),
        .SW_O    (SW_O),
        .SW_RISE (SW_RISE),
        .SW_FALL (SW_FALL),
        .PULSE_O (PULSE_O)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: input seen two edges late, sampled every N edges
    // after reset release; a level is accepted once three consecutive
    // samples agree on it.
    logic [7:0] m_del [2];
    logic [7:0] m_win [2];
    logic [7:0] m_sw, m_rise, m_fall;
    logic       m_pulse, m_prev;
    int         m_edges;
    bit         m_valid = 1'b0;

    always @(posedge CLK) begin
        logic [7:0] s, nsw, nr, nf;
        if (RST) begin
            m_del[0] <= 8'h00; m_del[1] <= 8'h00;
            m_win[0] <= 8'h00; m_win[1] <= 8'h00;
            m_sw <= 8'h00; m_rise <= 8'h00; m_fall <= 8'h00;
            m_pulse <= 1'b0; m_prev <= 1'b0;
            m_edges <= 0;
            m_valid <= 1'b1;
        end else begin
            s   = m_del[1];
            nsw = m_sw;
            nr  = 8'h00;
            nf  = 8'h00;
            if ((m_edges + 1) % N == 0) begin
                for (int b = 0; b < 8; b++) begin
                    if (s[b] == m_win[0][b] && s[b] == m_win[1][b] && s[b] != m_sw[b]) begin
                        nsw[b] = s[b];
                        if (s[b]) nr[b] = 1'b1;
                        else      nf[b] = 1'b1;
                    end
                end
                m_win[1] <= m_win[0];
                m_win[0] <= s;
            end
            m_del[1] <= m_del[0];
            m_del[0] <= SW_I;
            m_edges  <= m_edges + 1;
            m_sw     <= nsw;
            m_rise   <= nr;
            m_fall   <= nf;
            m_pulse  <= PULSE_I & ~m_prev;
            m_prev   <= PULSE_I;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("sw_o",    {24'd0, SW_O},    {24'd0, m_sw});
            chk("sw_rise", {24'd0, SW_RISE}, {24'd0, m_rise});
            chk("sw_fall", {24'd0, SW_FALL}, {24'd0, m_fall});
            chk("pulse_o", {31'd0, PULSE_O}, {31'd0, m_pulse});
        end
    end

    always @(negedge CLK) begin
        if (PULSE_O) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_sw_o",    {24'd0, SW_O},    32'h0);
        chk("rst_sw_rise", {24'd0, SW_RISE}, 32'h0);
        chk("rst_sw_fall", {24'd0, SW_FALL}, 32'h0);
        chk("rst_pulse_o", {31'd0, PULSE_O}, 32'h0);
        RST = 1'b0;
    endtask

    // With SW_I=8'h01 held through reset, samples land on edges 16, 32, 48
    // after release, so SW_O changes exactly on edge 48.
    task automatic rise_check();
        do_reset();
        repeat (47) @(posedge CLK);
        #1 chk("lat_pre_sw_o", {24'd0, SW_O}, 32'h00);
        @(posedge CLK);
        #1;
        chk("lat_sw_o",    {24'd0, SW_O},    32'h01);
        chk("lat_sw_rise", {24'd0, SW_RISE}, 32'h01);
        chk("lat_sw_fall", {24'd0, SW_FALL}, 32'h00);
        @(posedge CLK);
        #1;
        chk("lat_rise_width", {24'd0, SW_RISE}, 32'h00);
        chk("lat_hold_sw_o",  {24'd0, SW_O},    32'h01);
    endtask

    initial begin
        int p0;
        logic [7:0] base, v;
        int len;

        // Reset and stable rise with exact latency.
        do_reset();
        @(negedge CLK);
        SW_I = 8'h01;
        rise_check();

        // Stable fall.
        @(negedge CLK);
        SW_I = 8'h00;
        repeat (70) @(negedge CLK);
        chk("fall_sw_o", {24'd0, SW_O}, 32'h00);

        // Glitch shorter than two sample periods.
        SW_I = 8'h08;
        repeat (20) @(negedge CLK);
        SW_I = 8'h00;
        repeat (60) @(negedge CLK);
        chk("glitch_sw_o", {24'd0, SW_O}, 32'h00);

        // Bounce on bit 7, then settle high.
        for (int i = 0; i < 20; i++) begin
            SW_I[7] = ~SW_I[7];
            repeat (10) @(negedge CLK);
        end
        SW_I[7] = 1'b1;
        repeat (80) @(negedge CLK);
        chk("bounce_sw_o", {24'd0, SW_O}, 32'h80);

        // Held-high strobe gives one pulse; 1,0,1 gives two.
        p0 = pulse_cnt;
        PULSE_I = 1'b1;
        repeat (50) @(negedge CLK);
        PULSE_I = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pulse_held_count", pulse_cnt - p0, 32'd1);
        p0 = pulse_cnt;
        PULSE_I = 1'b1; @(negedge CLK);
        PULSE_I = 1'b0; @(negedge CLK);
        PULSE_I = 1'b1; @(negedge CLK);
        PULSE_I = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pulse_101_count", pulse_cnt - p0, 32'd2);

        // Reset after two of three agreeing samples discards the history.
        SW_I = 8'h01;
        do_reset();
        repeat (40) @(posedge CLK);
        #1 chk("mid_pre_sw_o", {24'd0, SW_O}, 32'h00);
        rise_check();

        // Randomized segments: long holds, short glitches, random strobes, rare resets.
        @(negedge CLK);
        base = SW_I;
        for (int s = 0; s < 150; s++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 30);
            else len = $urandom_range(20, 90);
            SW_I = v;
            for (int c = 0; c < len; c++) begin
                PULSE_I = 1'($urandom_range(0, 1));
                RST = ($urandom_range(0, 199) == 0);
                @(negedge CLK);
            end
            RST = 1'b0;
            if (len < 20) SW_I = base;
            else base = v;
        end
        PULSE_I = 1'b0;
        repeat (60) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_filter_pulse.md
# sw_filter_pulse

Debounces a P_DBUS_W-bit switch bus and derives single-cycle edge pulses for it and for a separate pulse input. It sits between the board I/O (switches and strobe sources) and control logic that needs clean levels and one-cycle events. It combines the PULSE_GEN and SW_FILTER functions in one clock domain.

## Interface
- P_SIM, 0: 1 selects the simulation sample period of 16 clocks instead of P_SAMP_CNT.
- P_DBUS_W, 8: switch bus width, 1..32.
- P_INIT_VAL, 1'b0: reset value of every switch bit in the synchronizer, history and SW_O.
- P_SAMP_CNT, 10000: sample period in clocks, 2..65536 (100 µs at 100 MHz).
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- SW_I  in  P_DBUS_W  raw, asynchronous switch inputs.
- PULSE_I  in  1  level/strobe input, synchronous to CLK.
- SW_O  out  P_DBUS_W  debounced switch levels.
- SW_RISE  out  P_DBUS_W  per-bit one-cycle pulse when SW_O bit goes 0→1.
- SW_FALL  out  P_DBUS_W  per-bit one-cycle pulse when SW_O bit goes 1→0.
- PULSE_O  out  1  one-cycle pulse per rising edge of PULSE_I.

## Operation
- Sample period: N = 16 if P_SIM=1, else P_SAMP_CNT.
- Sample counter:
  - 16-bit, counts 0..N-1 and then wraps to 0.
  - samp_en is high for exactly one cycle when the count equals N-1.
  - The first samp_en after reset occurs N cycles after reset is released.
- Synchronizer: 2-flop synchronizer per bit on SW_I, giving sw_s.
- History:
  - On samp_en, each bit shifts sw_s into a 3-deep history h[2:0], with h[0] as the newest.
  - The history updates only on samp_en.
- Filter decision, evaluated per bit on each samp_en, using the new sample together with h[0] and h[1]:
  - All three equal and different from SW_O: SW_O takes that value on the same clock edge.
  - Otherwise: SW_O holds its value.
- Edge pulses:
  - SW_RISE and SW_FALL are registered. They are high in the cycle in which SW_O first shows the new value.
  - They are one cycle wide, and only one of the two can be high per bit.
- Bits are independent. Several bits may change on the same samp_en.
- Pulse generator:
  - The register p_d holds the previous PULSE_I.
  - PULSE_O is registered as PULSE_I & ~p_d.
  - A held-high PULSE_I gives exactly one pulse.
  - Back-to-back 1-cycle pulses separated by one low cycle give two PULSE_O pulses.
- Reset values:
  - p_d resets to 0, so PULSE_I high on the first cycle after reset produces a pulse.
  - All other reset values are listed under Timing.

## Timing
- Reset, applied on the first rising edge with RST=1:
  - Counter is 0.
  - Synchronizer, history and SW_O are all bits P_INIT_VAL.
  - SW_RISE, SW_FALL, PULSE_O and p_d are 0.
- RST asserted mid-operation:
  - Every register returns to its reset value on the next edge.
  - Any partially accumulated history is discarded.
  - No edge pulse is generated by the reset itself.
- SW_I to sw_s: 2 cycles.
- SW_O latency after a stable SW_I change:
  - The third samp_en at which the new value is sampled, plus 0 cycles.
  - Worst case: 2 + 3N cycles.
  - Best case: 2 + 2N + 1 cycles.
- SW_RISE/SW_FALL coincide with the first cycle of the new SW_O value.
- PULSE_O: 1 cycle after the PULSE_I rising edge, exactly 1 cycle wide.
- Glitch rejection: an input glitch shorter than 2 consecutive sample periods never changes SW_O.
- Counter wrap: N-1 → 0 with no missing or extra samp_en. With N=65536 the 16-bit counter wraps naturally.

## Test plan
All scenarios use P_SIM=1 (N=16), P_DBUS_W=8 and P_INIT_VAL=0.

1. Reset: hold RST for 3 cycles → SW_O=8'h00, SW_RISE=SW_FALL=0 and PULSE_O=0. The first samp_en occurs at cycle 16 after release.
2. Stable change: SW_I=8'h01 held → SW_O[0]=1 within 2+48 cycles, with SW_RISE=8'h01 for exactly 1 cycle and SW_FALL=0. Setting SW_I=0 again → SW_FALL=8'h01 pulse and SW_O=0.
3. Glitch rejection: SW_I[3] toggled high for 20 cycles, then low → SW_O stays 8'h00 and no pulses are produced.
4. Bounce: SW_I[7] alternates every 10 cycles for 200 cycles, then settles at 1 → SW_O[7] rises only after 3 consecutive high samples, with a single SW_RISE.
5. PULSE_I held high for 50 cycles → one PULSE_O pulse, 1 cycle after the rise. Pattern 1,0,1 → two PULSE_O pulses.
6. Mid-operation reset: RST after 2 of 3 equal samples → SW_O=8'h00, then 3 fresh samples are needed before SW_O changes.
